// File: rtl/svm_pkg.sv
// Shared types and default sizing for the counter arbiter slice.
package svm_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      START   = 2'd1,
      RUN     = 2'd2,
      RELEASE = 2'd3
   } arb_state_t;

   localparam int REQUESTERS_DEF = 4;
   localparam int TIMEOUT_DEF    = 4096;

endpackage

// File: rtl/counter_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit at or above ptr, wrapping
// explicitly at Requesters so non-power-of-two client counts work.
module rr_pick #(
   parameter int Requesters = 4
) (
   input  logic [Requesters-1:0]         req,
   input  logic [$clog2(Requesters)-1:0] ptr,
   output logic [$clog2(Requesters)-1:0] winner,
   output logic                          any
);

   localparam int PtrW = $clog2(Requesters);

   always_comb begin
      int idx;
      idx    = 0;
      winner = '0;
      any    = 1'b0;
      for (int i = 0; i < Requesters; i++) begin
         idx = int'(ptr) + i;
         if (idx >= Requesters) idx = idx - Requesters;
         if (!any && req[idx]) begin
            any    = 1'b1;
            winner = PtrW'(idx);
         end
      end
   end

endmodule

// File: rtl/counter_arbiter.sv
// Round-robin arbiter sharing one mem_counter between Requesters clients.
// Define COUNTER_ARBITER_TIMEOUT_EN to abort a RUN after TimeoutCycles and pulse timeout.
module counter_arbiter
   import svm_pkg::*;
#(
   parameter int Requesters    = REQUESTERS_DEF,
   parameter int TimeoutCycles = TIMEOUT_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [Requesters-1:0] req,
   output logic [Requesters-1:0] grant,
   output logic                  ctr_start,
   input  logic                  ctr_stop,
   output logic [Requesters-1:0] done,
   output logic                  busy
`ifdef COUNTER_ARBITER_TIMEOUT_EN
   ,
   output logic                  timeout
`endif
);

   localparam int PtrW = $clog2(Requesters);
   localparam logic [PtrW-1:0] LastIdx = PtrW'(Requesters - 1);

   if (Requesters < 2 || Requesters > 16 || TimeoutCycles < 1) begin : g_bad_cfg
      $error("counter_arbiter: Requesters must be 2..16 and TimeoutCycles >= 1");
   end

   arb_state_t            state;
   logic [PtrW-1:0]       ptr;
   logic [PtrW-1:0]       win_q;
   logic [PtrW-1:0]       pick_win;
   logic                  pick_any;
   logic [Requesters-1:0] pick_oh;
   logic                  run_end;

   rr_pick #(.Requesters(Requesters)) u_pick (
      .req    (req),
      .ptr    (ptr),
      .winner (pick_win),
      .any    (pick_any)
   );

   always_comb begin
      pick_oh           = '0;
      pick_oh[pick_win] = 1'b1;
   end

`ifdef COUNTER_ARBITER_TIMEOUT_EN
   localparam int CntW = $clog2(TimeoutCycles + 1);
   localparam logic [CntW-1:0] CntLast = CntW'(TimeoutCycles - 1);

   logic [CntW-1:0] run_cnt;
   logic            to_hit;

   // run_cnt is 0 in the first RUN cycle, so hitting CntLast means TimeoutCycles RUN cycles elapsed
   assign to_hit  = (run_cnt == CntLast);
   assign run_end = ctr_stop || to_hit;
`else
   assign run_end = ctr_stop;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         ptr       <= '0;
         win_q     <= '0;
         grant     <= '0;
         done      <= '0;
         ctr_start <= 1'b0;
         busy      <= 1'b0;
`ifdef COUNTER_ARBITER_TIMEOUT_EN
         run_cnt   <= '0;
         timeout   <= 1'b0;
`endif
      end else begin
         ctr_start <= 1'b0;
         done      <= '0;
`ifdef COUNTER_ARBITER_TIMEOUT_EN
         timeout   <= 1'b0;
`endif
         case (state)
            IDLE: begin
               if (pick_any) begin
                  state     <= START;
                  win_q     <= pick_win;
                  grant     <= pick_oh;
                  ctr_start <= 1'b1;
                  busy      <= 1'b1;
               end
            end
            START: begin
               state <= RUN;
`ifdef COUNTER_ARBITER_TIMEOUT_EN
               run_cnt <= '0;
`endif
            end
            RUN: begin
               // owner comes from win_q/grant, so req changes here never reassign it
               if (run_end) begin
                  state <= RELEASE;
                  done  <= grant;
                  grant <= '0;
                  ptr   <= (win_q == LastIdx) ? '0 : win_q + 1'b1;
`ifdef COUNTER_ARBITER_TIMEOUT_EN
                  timeout <= !ctr_stop;
`endif
               end
`ifdef COUNTER_ARBITER_TIMEOUT_EN
               else begin
                  run_cnt <= run_cnt + 1'b1;
               end
`endif
            end
            RELEASE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               grant <= '0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
